// File: rtl/xm_ovf_stage_pkg.sv
// Shared definitions for the execute->memory overflow stage: op classes,
// overflow status codes and the status register index.
package xm_ovf_stage_pkg;

  typedef enum logic [1:0] {
    OpOther = 2'b00,
    OpAdd   = 2'b01,
    OpAddi  = 2'b10,
    OpSub   = 2'b11
  } op_class_e;

  localparam logic [1:0] CodeAdd  = 2'd1;
  localparam logic [1:0] CodeAddi = 2'd2;
  localparam logic [1:0] CodeSub  = 2'd3;

  localparam int unsigned StatusRegIdx = 30;

  function automatic logic [1:0] ovf_code(op_class_e op);
    logic [1:0] code;
    code = 2'd0;
    unique case (op)
      OpAdd:   code = CodeAdd;
      OpAddi:  code = CodeAddi;
      OpSub:   code = CodeSub;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/xm_ovf_stage_if.sv
// Execute-side inputs and memory-side outputs of the overflow stage.
// The master modport drives the stage; the slave modport is the stage itself.
interface xm_ovf_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic              in_stall;
  logic              in_flush;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic [1:0]        op_class;
  logic [REG_W-1:0]  rd;
  logic              rd_we;
  logic              exc_clear;

  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_we;
  logic              out_exc;
  logic              exc_sticky;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output in_valid, in_stall, in_flush, alu_result, alu_ovf, op_class, rd, rd_we, exc_clear,
    input  out_valid, out_result, out_rd, out_we, out_exc, exc_sticky, exc_count
  );

  modport slave (
    input  in_valid, in_stall, in_flush, alu_result, alu_ovf, op_class, rd, rd_we, exc_clear,
    output out_valid, out_result, out_rd, out_we, out_exc, exc_sticky, exc_count
  );
endinterface

// File: rtl/xm_ovf_stage_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; a clear coinciding
// with an increment loads 1.
module xm_ovf_stage_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? Width'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xm_ovf_stage.sv
// Execute->memory pipeline register that redirects overflowing add/addi/sub
// writebacks to the status register and tracks overflow exceptions.
module xm_ovf_stage
  import xm_ovf_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned STATUS_REG = StatusRegIdx,
  parameter int unsigned CNT_W      = 8
) (
  input logic          clock,
  input logic          reset,
  xm_ovf_stage_if.slave bus_io
);

  op_class_e op;
  logic      exc;
  logic      capture;
  logic      exc_capt;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              we_q, we_d;
  logic              exc_q, exc_d;
  logic              sticky_q, sticky_d;

  assign op       = op_class_e'(bus_io.op_class);
  assign exc      = bus_io.in_valid & bus_io.alu_ovf & (op != OpOther);
  assign capture  = ~bus_io.in_flush & ~bus_io.in_stall;
  assign exc_capt = capture & exc;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    exc_d    = exc_q;
    if (bus_io.in_flush) begin
      // Flush only kills the control bits; data fields keep their old value.
      valid_d = 1'b0;
      we_d    = 1'b0;
      exc_d   = 1'b0;
    end else if (!bus_io.in_stall) begin
      valid_d = bus_io.in_valid;
      exc_d   = exc;
      if (exc) begin
        result_d = DATA_W'(ovf_code(op));
        rd_d     = REG_W'(STATUS_REG);
        we_d     = 1'b1;
      end else begin
        result_d = bus_io.alu_result;
        rd_d     = bus_io.rd;
        we_d     = bus_io.in_valid & bus_io.rd_we & (bus_io.rd != '0);
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (bus_io.exc_clear) sticky_d = 1'b0;
    if (exc_capt)         sticky_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      exc_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      exc_q    <= exc_d;
      sticky_q <= sticky_d;
    end
  end

  xm_ovf_stage_sat_counter #(
    .Width (CNT_W)
  ) u_exc_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (bus_io.exc_clear),
    .inc_i (exc_capt),
    .cnt_o (bus_io.exc_count)
  );

  assign bus_io.out_valid  = valid_q;
  assign bus_io.out_result = result_q;
  assign bus_io.out_rd     = rd_q;
  assign bus_io.out_we     = we_q;
  assign bus_io.out_exc    = exc_q;
  assign bus_io.exc_sticky = sticky_q;

endmodule
